icmp_rx: RTL and testbench

- Receive-side ICMP echo-request parser.
- Watches the Ethernet receive byte stream and recognises IPv4 ICMP echo requests addressed to our IP.
- Streams the requester fields the reply builder needs onto the 11-bit icmp_bus, adjusting the ICMP checksum for the type change 8→0.
- At frame end it issues a one-cycle strobe plus an accept/reject flag; the ICMP transmit side consumes icmp_bus and turns it into a reply request.

---
 rtl/icmp_rx.sv | 126 ++++++++++++
 tb/tb_icmp_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/icmp_rx.sv
// rtl/icmp_rx.sv - ICMP echo-request receive parser feeding the reply builder over icmp_bus
module icmp_rx #(
  parameter logic [31:0] ip        = 32'hC0A80702,
  parameter int          max_store = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        rx_crc_ok,
  input  logic        tx_busy,
  input  logic [8:0]  address_set,
  output logic [10:0] icmp_bus,
  output logic [15:0] reply_cnt
);

  localparam int CW = $clog2(max_store + 1);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, PARSE, END} state_t;

  state_t        state_q, state_d;
  logic [10:0]   off_q, cur_off;
  logic          drop_q, drop_d, drop_base;
  logic [CW-1:0] wr_cnt_q, wr_cnt_base;
  logic [31:0]   ip_q, fip_q, cur_ip;
  logic          start, frame_byte, mismatch, store_pos, overflow, wr_d, ok_now;
  logic          s1_wr_q, s1_is36_q, s1_is37_q, end_q, ok_q;
  logic [7:0]    s1_data_q, c_lo_q;
  logic [16:0]   s17;
  logic [15:0]   c16;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      WAIT_LOW: if (!rx_strobe) state_d = IDLE;
      IDLE, END: begin
        state_d = IDLE;
        if (rx_strobe) begin
          state_d = PARSE;
          start   = 1'b1;
        end
      end
      PARSE:   if (!rx_strobe) state_d = END;
      default: state_d = WAIT_LOW;
    endcase
  end

  // The first byte of a frame arrives while still in IDLE/END, so its offset is forced to 0.
  always_comb begin
    frame_byte  = rx_strobe && (start || state_q == PARSE);
    cur_off     = start ? 11'd0 : off_q;
    cur_ip      = start ? ip_q : fip_q;
    drop_base   = start ? 1'b0 : drop_q;
    wr_cnt_base = start ? '0 : wr_cnt_q;
    mismatch    = 1'b0;
    case (cur_off)
      11'd12:  mismatch = (rx_data != 8'h08);
      11'd13:  mismatch = (rx_data != 8'h00);
      11'd14:  mismatch = (rx_data != 8'h45);
      11'd23:  mismatch = (rx_data != 8'h01);
      11'd30:  mismatch = (rx_data != cur_ip[31:24]);
      11'd31:  mismatch = (rx_data != cur_ip[23:16]);
      11'd32:  mismatch = (rx_data != cur_ip[15:8]);
      11'd33:  mismatch = (rx_data != cur_ip[7:0]);
      11'd34:  mismatch = (rx_data != 8'h08);
      11'd35:  mismatch = (rx_data != 8'h00);
      default: mismatch = 1'b0;
    endcase
    store_pos = (cur_off >= 11'd6  && cur_off <= 11'd11) ||
                (cur_off >= 11'd16 && cur_off <= 11'd22) ||
                (cur_off >= 11'd24 && cur_off <= 11'd29) ||
                (cur_off >= 11'd36);
    overflow  = store_pos && (wr_cnt_base == CW'(max_store));
    drop_d    = drop_base | (frame_byte & (mismatch | tx_busy | overflow));
    wr_d      = frame_byte & store_pos & ~drop_d;
    ok_now    = ~drop_q & rx_crc_ok & (off_q >= 11'd38);
    // Echo type 8 -> 0 raises the one's-complement checksum by 0x0800 with end-around carry.
    s17       = {1'b0, s1_data_q, rx_data} + 17'h00800;
    c16       = s17[15:0] + {15'd0, s17[16]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOW;
      off_q     <= '0;
      drop_q    <= 1'b0;
      wr_cnt_q  <= '0;
      ip_q      <= ip;
      fip_q     <= ip;
      s1_wr_q   <= 1'b0;
      s1_is36_q <= 1'b0;
      s1_is37_q <= 1'b0;
      s1_data_q <= '0;
      c_lo_q    <= '0;
      end_q     <= 1'b0;
      ok_q      <= 1'b0;
      icmp_bus  <= '0;
      reply_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (address_set[8]) ip_q <= {ip_q[23:0], address_set[7:0]};
      if (frame_byte) begin
        off_q    <= (cur_off == 11'h7FF) ? cur_off : cur_off + 11'd1;
        drop_q   <= drop_d;
        wr_cnt_q <= wr_cnt_base + CW'(wr_d);
        if (start) fip_q <= ip_q;
      end
      s1_wr_q   <= wr_d;
      s1_data_q <= rx_data;
      s1_is36_q <= wr_d && cur_off == 11'd36;
      s1_is37_q <= wr_d && cur_off == 11'd37;
      if (s1_is36_q) c_lo_q <= c16[7:0];
      end_q <= (state_q == PARSE) && !rx_strobe;
      ok_q  <= ok_now;
      icmp_bus[8]    <= s1_wr_q;
      icmp_bus[7:0]  <= !s1_wr_q ? 8'h00 :
                        s1_is36_q ? c16[15:8] :
                        s1_is37_q ? c_lo_q : s1_data_q;
      icmp_bus[9]    <= end_q;
      icmp_bus[10]   <= end_q & ok_q;
      if (end_q && ok_q) reply_cnt <= reply_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_icmp_rx.sv
// tb/tb_icmp_rx.sv - directed self-checking bench for icmp_rx
module tb_icmp_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_strobe, rx_crc_ok, tx_busy;
  logic [8:0]  address_set;
  logic [10:0] icmp_bus;
  logic [15:0] reply_cnt;

  always #5 clk = ~clk;

  icmp_rx dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .rx_crc_ok(rx_crc_ok), .tx_busy(tx_busy), .address_set(address_set),
    .icmp_bus(icmp_bus), .reply_cnt(reply_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int e_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fr [0:255];
  int         tx_cyc [0:255];
  logic [7:0] wq_data [$];
  int         wq_cyc [$];
  logic       sq_ok [$];
  int         sq_cyc [$];
  int         both_seen = 0;

  always @(negedge clk) begin
    if (icmp_bus[8]) begin
      wq_data.push_back(icmp_bus[7:0]);
      wq_cyc.push_back(cyc);
    end
    if (icmp_bus[9]) begin
      sq_ok.push_back(icmp_bus[10]);
      sq_cyc.push_back(cyc);
    end
    if (icmp_bus[8] && icmp_bus[9]) both_seen++;
  end

  task automatic clear_q();
    wq_data.delete(); wq_cyc.delete(); sq_ok.delete(); sq_cyc.delete();
  endtask

  function automatic bit stored(input int o);
    return (o >= 6 && o <= 11) || (o >= 16 && o <= 22) || (o >= 24 && o <= 29) || o >= 36;
  endfunction

  task automatic build(input int len, input logic [31:0] dip, input logic [15:0] ck);
    for (int i = 0; i < len; i++) fr[i] = 8'(i * 7 + 3);
    fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45; fr[23] = 8'h01;
    fr[30] = dip[31:24]; fr[31] = dip[23:16]; fr[32] = dip[15:8]; fr[33] = dip[7:0];
    fr[34] = 8'h08; fr[35] = 8'h00; fr[36] = ck[15:8]; fr[37] = ck[7:0];
  endtask

  task automatic send(input int len, input logic crc, input int busy_off);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      rx_data = fr[i]; rx_strobe = 1'b1; tx_busy = (i == busy_off); tx_cyc[i] = cyc;
    end
    @(posedge clk); #1;
    rx_strobe = 1'b0; tx_busy = 1'b0; rx_crc_ok = crc; e_cyc = cyc;
    @(posedge clk); #1;
    rx_crc_ok = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int len, input logic crc, input int busy_off,
                     input int stop, input logic exp_ok);
    logic [7:0]  ed [$];
    int          ec [$];
    logic [16:0] s;
    logic [15:0] c;
    int          n;
    clear_q();
    send(len, crc, busy_off);
    s = {1'b0, fr[36], fr[37]} + 17'h00800;
    c = s[15:0] + {15'd0, s[16]};
    for (int o = 0; o < len; o++) begin
      if (o < stop && stored(o) && ed.size() < 128) begin
        ed.push_back(o == 36 ? c[15:8] : (o == 37 ? c[7:0] : fr[o]));
        ec.push_back(tx_cyc[o] + 2);
      end
    end
    check({tag, "_nwr"}, wq_data.size(), ed.size());
    n = (wq_data.size() < ed.size()) ? wq_data.size() : ed.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_d%0d", tag, i), wq_data[i], ed[i]);
      check($sformatf("%s_t%0d", tag, i), wq_cyc[i], ec[i]);
    end
    check({tag, "_nstb"}, sq_ok.size(), 1);
    if (sq_ok.size() > 0) begin
      check({tag, "_ok"}, sq_ok[0], exp_ok);
      check({tag, "_tstb"}, sq_cyc[0], e_cyc + 2);
    end
    if (exp_ok) exp_cnt++;
    check({tag, "_cnt"}, reply_cnt, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_strobe = 1'b0; rx_crc_ok = 1'b0;
    tx_busy = 1'b0; address_set = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus", icmp_bus, 0);
    check("rst_cnt", reply_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    build(74, 32'hC0A80702, 16'h4D5A);
    run("valid", 74, 1'b1, -1, 4096, 1'b1);
    check("valid_n57", wq_data.size(), 57);
    check("valid_ck_hi", wq_data[19], 8'h55);
    check("valid_ck_lo", wq_data[20], 8'h5A);
    check("valid_cnt1", reply_cnt, 1);

    build(74, 32'hC0A80702, 16'hF900);
    run("wrap1", 74, 1'b1, -1, 4096, 1'b1);
    check("wrap1_hi", wq_data[19], 8'h01);
    check("wrap1_lo", wq_data[20], 8'h01);

    build(74, 32'hC0A80702, 16'hF7FF);
    run("wrap2", 74, 1'b1, -1, 4096, 1'b1);
    check("wrap2_hi", wq_data[19], 8'hFF);
    check("wrap2_lo", wq_data[20], 8'hFF);

    build(74, 32'hC0A80703, 16'h4D5A);
    run("badip", 74, 1'b1, -1, 33, 1'b0);
    check("badip_n19", wq_data.size(), 19);

    build(74, 32'hC0A80702, 16'h4D5A);
    run("badcrc", 74, 1'b0, -1, 4096, 1'b0);

    foreach (fr[i]) if (i < 4) begin
      @(posedge clk); #1;
      address_set = {1'b1, (i == 0) ? 8'h0A : (i == 3) ? 8'h05 : 8'h00};
    end
    @(posedge clk); #1;
    address_set = '0;
    build(74, 32'h0A000005, 16'h4D5A);
    run("newip", 74, 1'b1, -1, 4096, 1'b1);
    build(74, 32'hC0A80702, 16'h4D5A);
    run("oldip", 74, 1'b1, -1, 30, 1'b0);

    build(74, 32'h0A000005, 16'h4D5A);
    run("busy", 74, 1'b1, 40, 40, 1'b0);
    check("busy_n23", wq_data.size(), 23);

    build(200, 32'h0A000005, 16'h4D5A);
    run("long", 200, 1'b1, -1, 4096, 1'b0);
    check("long_n128", wq_data.size(), 128);

    build(74, 32'h0A000005, 16'h4D5A);
    for (int i = 0; i < 74; i++) begin
      @(posedge clk); #1;
      rx_data = fr[i]; rx_strobe = 1'b1;
      if (i == 20) rst_n = 1'b0;
      if (i == 21) begin
        rst_n = 1'b1;
        clear_q();
      end
    end
    @(posedge clk); #1;
    rx_strobe = 1'b0; rx_crc_ok = 1'b1;
    @(posedge clk); #1;
    rx_crc_ok = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_nwr", wq_data.size(), 0);
    check("abort_nstb", sq_ok.size(), 0);
    check("abort_cnt", reply_cnt, 0);
    exp_cnt = 0;
    build(74, 32'hC0A80702, 16'h4D5A);
    run("after", 74, 1'b1, -1, 4096, 1'b1);

    check("wr_stb_excl", both_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
